// File: rtl/svx32_mem_pkg.sv
// rtl/svx32_mem_pkg.sv - shared types and widths for the svx32 data-memory responder
package svx32_mem_pkg;

    localparam int DATA_W = 32;
    localparam int LANES  = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Value loaded into the wait counter on capture; unused when latency is zero.
    function automatic logic [CNT_W-1:0] wait_load(input int lat);
        return (lat > 0) ? CNT_W'(lat - 1) : '0;
    endfunction

endpackage

// File: rtl/svx32_dmem_ram.sv
// rtl/svx32_dmem_ram.sv - single-port synchronous word RAM with byte-lane write enables
module svx32_dmem_ram
    import svx32_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              i_clk,
    input  logic [LANES-1:0]  i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Per-lane write and read-before-write registered read; contents are never reset.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/svx32_dmem_responder.sv
// rtl/svx32_dmem_responder.sv - request/ack data-memory responder with configurable wait states
module svx32_dmem_responder
    import svx32_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        pil_clk,
    input  logic        pil_rst_n,
    input  logic        pil_mem_req,
    input  logic        pil_mem_wen,
    input  logic [31:0] piv_mem_addr,
    input  logic [31:0] piv_mem_wdata,
    input  logic [3:0]  piv_mem_byte_sel,
    output logic        pol_mem_ack,
    output logic        pol_mem_valid,
    output logic [31:0] pov_mem_rdata,
    output logic        pol_mem_err
);

    localparam int                AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LOAD = wait_load(LATENCY);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_wen;
    logic [AW-1:0]       r_index;
    logic [DATA_W-1:0]   r_wdata;
    logic [LANES-1:0]    r_byte_sel;
    logic                r_oor;
    logic                r_ack;
    logic                r_valid;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;

    logic [31:0]         w_offset;
    logic [31:0]         w_word;
    logic                w_oor;
    logic [AW-1:0]       w_ram_addr;
    logic [LANES-1:0]    w_ram_we;
    logic [DATA_W-1:0]   w_ram_rdata;

    // Address decode of the incoming request: word index relative to BASE_ADDR, lane bits dropped.
    always_comb begin
        w_offset = piv_mem_addr - BASE_ADDR;
        w_word   = w_offset >> 2;
        w_oor    = (piv_mem_addr < BASE_ADDR) || (w_word >= 32'(DEPTH_WORDS));
    end

    // RAM is addressed from the live request in IDLE so a zero-latency read has data one edge
    // after capture; afterwards it keeps reading the captured index. Writes commit on the RESP edge.
    always_comb begin
        w_ram_addr = (r_state == ST_IDLE) ? w_word[AW-1:0] : r_index;
        w_ram_we   = '0;
        if ((r_state == ST_RESP) && r_wen && !r_oor) begin
            w_ram_we = r_byte_sel;
        end
    end

    svx32_dmem_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .i_clk   (pil_clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Transaction FSM: capture in IDLE, count wait states, pulse registered outputs in RESP.
    always_ff @(posedge pil_clk or negedge pil_rst_n) begin
        if (!pil_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_wen      <= 1'b0;
            r_index    <= '0;
            r_wdata    <= '0;
            r_byte_sel <= '0;
            r_oor      <= 1'b0;
            r_ack      <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_ack   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (pil_mem_req) begin
                        r_wen      <= pil_mem_wen;
                        r_index    <= w_word[AW-1:0];
                        r_wdata    <= piv_mem_wdata;
                        r_byte_sel <= piv_mem_byte_sel;
                        r_oor      <= w_oor;
                        r_cnt      <= WAIT_LOAD;
                        r_state    <= (LATENCY == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    r_ack <= 1'b1;
                    r_err <= r_oor;
                    if (!r_wen) begin
                        r_valid <= 1'b1;
                        r_rdata <= r_oor ? '0 : w_ram_rdata;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pol_mem_ack   = r_ack;
    assign pol_mem_valid = r_valid;
    assign pol_mem_err   = r_err;
    assign pov_mem_rdata = r_rdata;

endmodule

// File: tb/tb_svx32_dmem_responder.sv
// tb/tb_svx32_dmem_responder.sv - scoreboard bench for svx32_dmem_responder at latencies 1, 0 and 15
module tb_svx32_dmem_responder;

    typedef struct {
        int          g;
        int          ack_cyc;
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req   [3];
    logic        wen   [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  bsel  [3];
    logic        ack   [3];
    logic        valid [3];
    logic        err   [3];
    logic [31:0] rdata [3];

    logic [31:0] last_rd [3];
    exp_t        sb [$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int          LAT_G  = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
        localparam logic [31:0] BASE_G = (g == 1) ? 32'h0000_1000 : 32'h0000_0000;

        svx32_dmem_responder #(
            .DEPTH_WORDS (16),
            .LATENCY     (LAT_G),
            .BASE_ADDR   (BASE_G)
        ) u_dut (
            .pil_clk          (clk),
            .pil_rst_n        (rst_n),
            .pil_mem_req      (req[g]),
            .pil_mem_wen      (wen[g]),
            .piv_mem_addr     (addr[g]),
            .piv_mem_wdata    (wdata[g]),
            .piv_mem_byte_sel (bsel[g]),
            .pol_mem_ack      (ack[g]),
            .pol_mem_valid    (valid[g]),
            .pov_mem_rdata    (rdata[g]),
            .pol_mem_err      (err[g])
        );

        exp_t e;

        always @(negedge clk) begin
            if (ack[g] === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ack dut%0d: ack=1 at cycle %0d, required no ack", g, cyc);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("dut%0d owner", g), 32'(g), 32'(e.g));
                    chk($sformatf("dut%0d ack_cycle", g), 32'(cyc), 32'(e.ack_cyc));
                    chk($sformatf("dut%0d valid", g), {31'b0, valid[g]}, {31'b0, e.valid});
                    chk($sformatf("dut%0d err", g), {31'b0, err[g]}, {31'b0, e.err});
                    chk($sformatf("dut%0d rdata", g), rdata[g], e.rdata);
                end
            end else if (valid[g] === 1'b1 || err[g] === 1'b1) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stray_flag dut%0d: valid=%b err=%b without ack at cycle %0d, required 0", g, valid[g], err[g], cyc);
            end
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 0 : 15);
    endfunction

    // Hold req until ack, scrambling the other inputs after capture; returns on the ack negedge.
    task automatic wait_ack(input int g);
        int n;
        n = 0;
        @(negedge clk);
        addr[g]  = $urandom;
        wdata[g] = $urandom;
        wen[g]   = 1'($urandom);
        bsel[g]  = 4'($urandom);
        while (ack[g] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (ack[g] !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout dut%0d: no ack within 40 cycles, required ack", g);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    task automatic issue(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] bs, input logic [31:0] exp_rd, input logic exp_err);
        exp_t x;
        req[g]   = 1'b1;
        wen[g]   = w;
        addr[g]  = a;
        wdata[g] = d;
        bsel[g]  = bs;
        if (!w) last_rd[g] = exp_err ? 32'h0 : exp_rd;
        x.g       = g;
        x.ack_cyc = cyc + 2 + lat_of(g);
        x.valid   = !w;
        x.err     = exp_err;
        x.rdata   = last_rd[g];
        sb.push_back(x);
        wait_ack(g);
    endtask

    task automatic idle(input int g, input int n);
        req[g] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; wen[i] = 1'b0; addr[i] = '0; wdata[i] = '0; bsel[i] = '0;
            last_rd[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset dut%0d ack", i), {31'b0, ack[i]}, 32'h0);
            chk($sformatf("reset dut%0d valid", i), {31'b0, valid[i]}, 32'h0);
            chk($sformatf("reset dut%0d err", i), {31'b0, err[i]}, 32'h0);
            chk($sformatf("reset dut%0d rdata", i), rdata[i], 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // LATENCY=1: write/read, partial write, lane bits ignored
        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);        idle(0, 1);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);        idle(0, 1);
        issue(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b0);        idle(0, 1);
        issue(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);     idle(0, 1);
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);        idle(0, 1);
        issue(0, 1'b0, 32'h13, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);        idle(0, 2);

        // Out of range with 16 words, and byte_sel=0 no-op write
        issue(0, 1'b1, 32'h00, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);        idle(0, 1);
        issue(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1);                idle(0, 1);
        issue(0, 1'b1, 32'h40, 32'h9999_9999, 4'hF, 32'h0, 1'b1);        idle(0, 1);
        issue(0, 1'b0, 32'h00, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);        idle(0, 1);
        issue(0, 1'b1, 32'h00, 32'h0000_0000, 4'h0, 32'h0, 1'b0);        idle(0, 1);
        issue(0, 1'b0, 32'h00, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);        idle(0, 1);

        // Back-to-back: req held through the ack cycle
        issue(0, 1'b1, 32'h24, 32'h0102_0304, 4'hF, 32'h0, 1'b0);
        issue(0, 1'b0, 32'h24, 32'h0, 4'h0, 32'h0102_0304, 1'b0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);        idle(0, 2);

        // LATENCY=0 with BASE_ADDR=0x1000
        issue(1, 1'b1, 32'h1004, 32'h55AA_55AA, 4'hF, 32'h0, 1'b0);
        issue(1, 1'b0, 32'h1004, 32'h0, 4'h0, 32'h55AA_55AA, 1'b0);      idle(1, 1);
        issue(1, 1'b0, 32'h0FFC, 32'h0, 4'h0, 32'h0, 1'b1);              idle(1, 1);
        issue(1, 1'b1, 32'h103C, 32'h0BAD_CAFE, 4'hF, 32'h0, 1'b0);      idle(1, 1);
        issue(1, 1'b0, 32'h103C, 32'h0, 4'h0, 32'h0BAD_CAFE, 1'b0);      idle(1, 1);
        issue(1, 1'b0, 32'h1040, 32'h0, 4'h0, 32'h0, 1'b1);              idle(1, 2);

        // LATENCY=15
        issue(2, 1'b1, 32'h30, 32'h1234_5678, 4'hF, 32'h0, 1'b0);        idle(2, 1);
        issue(2, 1'b0, 32'h30, 32'h0, 4'h0, 32'h1234_5678, 1'b0);        idle(2, 1);
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);        idle(0, 1);

        // Reset during WAIT of a write to 0x30: no ack, write dropped
        req[2] = 1'b1; wen[2] = 1'b1; addr[2] = 32'h30; wdata[2] = 32'hFFFF_FFFF; bsel[2] = 4'hF;
        repeat (5) @(negedge clk);
        req[2] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midreset dut%0d rdata", i), rdata[i], 32'h0);
            chk($sformatf("midreset dut%0d ack", i), {31'b0, ack[i]}, 32'h0);
            last_rd[i] = 32'h0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        issue(2, 1'b0, 32'h30, 32'h0, 4'h0, 32'h1234_5678, 1'b0);        idle(2, 1);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);        idle(0, 3);

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/svx32_dmem_responder.md
SVX32_DMEM_RESPONDER -- requirements
Module: svx32_dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words of backing store.
REQ-002 SHALL have parameter LATENCY, default 1, range 0..15, meaning the wait-state cycles inserted between request capture and response.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0.
REQ-004 SHALL have port pil_clk  in  1  clock; the design uses one clock only, all state on its rising edge.
REQ-005 SHALL have port pil_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pil_mem_req  in  1  core request, held high until ack.
REQ-007 SHALL have port pil_mem_wen  in  1  1 = write, 0 = read.
REQ-008 SHALL have port piv_mem_addr  in  32  byte address.
REQ-009 SHALL have port piv_mem_wdata  in  32  write data.
REQ-010 SHALL have port piv_mem_byte_sel  in  4  byte-lane enables, bit n selects wdata[8n+7:8n].
REQ-011 SHALL have port pol_mem_ack  out  1  one-cycle completion pulse.
REQ-012 SHALL have port pol_mem_valid  out  1  one-cycle read-data-valid pulse.
REQ-013 SHALL have port pov_mem_rdata  out  32  read data.
REQ-014 SHALL have port pol_mem_err  out  1  one-cycle out-of-range flag, coincident with ack.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL, in IDLE with pil_mem_req=1 at edge T, capture wen, addr, wdata and byte_sel, and leave IDLE.
- LATENCY=0: the next state is RESP.
- LATENCY>0: the next state is WAIT, with the counter loaded to LATENCY-1.
REQ-017 SHALL, in WAIT, decrement the counter each cycle and enter RESP when it reaches 0, so that ack is high in cycle T+1+LATENCY.
REQ-018 SHALL ignore all request inputs while in WAIT or RESP.
REQ-019 SHALL, in RESP, assert pol_mem_ack for exactly one cycle and return to IDLE.
REQ-020 SHALL, for reads, assert pol_mem_valid in the same cycle as ack, with pov_mem_rdata holding the addressed word.
REQ-021 SHALL hold pov_mem_rdata stable until the next read response; writes do not change it.
REQ-022 SHALL, for writes, update only the lanes whose byte_sel bit is set, committed no later than the ack cycle.
REQ-023 SHALL treat a write with byte_sel=4'b0000 as a no-op that still acks.
REQ-024 SHALL compute the word index as (addr - BASE_ADDR) >> 2 and ignore addr[1:0].
REQ-025 SHALL classify an access as out of range when addr < BASE_ADDR or index >= DEPTH_WORDS.
- Out-of-range read: returns rdata=0 and asserts valid.
- Out-of-range write: data discarded.
- In both cases pol_mem_err pulses with ack.
REQ-026 SHALL treat pil_mem_req still high in IDLE on the cycle after ack as a new request; back-to-back requests are therefore spaced by at least 2+LATENCY cycles.
REQ-027 SHALL return a read of a word written in an earlier transaction with the written data, with no stale-data hazard.

Reset
REQ-028 SHALL, on pil_rst_n=0 at any time, immediately force the FSM to IDLE, the counter to 0, and ack, valid and err to 0.
REQ-029 SHALL reset pov_mem_rdata to 32'h0.
REQ-030 SHALL not reset memory contents; a reset mid-transaction abandons the transaction with no ack, and an uncommitted write is dropped.
REQ-031 SHALL, after reset deassertion, sample requests from the first rising edge.

Structure
REQ-032 SHALL take the FSM state enum, data width (32), byte-lane count (4) and latency counter width (4) from shared package svx32_mem_pkg.
REQ-033 SHALL place the backing store in sub-module svx32_dmem_ram: synchronous, byte-lane write enables, one read/write port, no reset.
REQ-034 SHALL contain no combinational path from any input to any output; all outputs are registered.

Verification
REQ-035 SHALL cover LATENCY=1 write then read:
- Stimulus: write addr 0x10, data 0xDEADBEEF, byte_sel 4'hF; then read 0x10.
- Required: write ack at T+2; read valid and ack at its own T+2 with rdata=0xDEADBEEF and err=0.
REQ-036 SHALL cover a partial write:
- Stimulus: write 0x11223344 to addr 0x20; then write data 0xAABBCCDD with byte_sel 4'b0101; then read 0x20.
- Required: read returns 0x11BB33DD.
REQ-037 SHALL cover out-of-range access with DEPTH_WORDS=16:
- Stimulus: read 0x40.
- Required: ack, valid and err high together, rdata=0.
- Stimulus: write 0x40, then read word 0.
- Required: the write causes no change to word 0.
REQ-038 SHALL cover the LATENCY extremes:
- LATENCY=0: ack exactly 1 cycle after capture.
- LATENCY=15: ack exactly 16 cycles after capture.
- Input changes during WAIT do not alter the response.
REQ-039 SHALL cover reset mid-operation:
- Stimulus: assert pil_rst_n=0 during WAIT of a write to 0x30.
- Required: outputs go to 0 immediately; no ack appears after release; a later read of 0x30 returns the pre-write value.
REQ-040 SHALL cover back-to-back requests:
- Stimulus: keep req high across the ack cycle.
- Required: a second transaction starts at ack+1, and exactly one ack is produced per transaction.
